// File: rtl/r4_ifft_pkg.sv
// Shared constants, types and the output round/saturate helper for the IFFT twiddle stage.
// Defining R4_TWIDDLE_SAT_EN clamps results to the signed WIDTH range; otherwise they wrap.
package r4_ifft_pkg;

  localparam int WIDTH = 26;
  localparam int CW    = 16;
  localparam int FRAC  = CW - 2;
  localparam int N     = 2048;
  localparam int LOGN  = $clog2(N);
  localparam int PRODW = WIDTH + CW;
  localparam int ACCW  = WIDTH + CW + 1;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  typedef logic signed [CW-1:0] coef_t;

  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(2 ** (FRAC - 1));

`ifdef R4_TWIDDLE_SAT_EN
  localparam logic signed [ACCW-FRAC-1:0] SH_MAX = (ACCW-FRAC)'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACCW-FRAC-1:0] SH_MIN = (ACCW-FRAC)'(-(2 ** (WIDTH - 1)));
`endif

  // Round half-up at the Q2.14 binary point, then clamp or wrap to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACCW-1:0] acc_i);
`ifdef R4_TWIDDLE_SAT_EN
    logic signed [ACCW-1:0]      sum;
    logic signed [ACCW-FRAC-1:0] sh;
    sum = acc_i + RND_HALF;
    sh  = sum[ACCW-1:FRAC];
    if (sh > SH_MAX) begin
      return WIDTH'(SH_MAX);
    end else if (sh < SH_MIN) begin
      return WIDTH'(SH_MIN);
    end else begin
      return WIDTH'(sh);
    end
`else
    return WIDTH'((acc_i + RND_HALF) >>> FRAC);
`endif
  endfunction

endpackage

// File: rtl/r4_twiddle_rom.sv
// Quarter-wave twiddle ROM: N/4 entries of {cos, sin} in Q2.14, one-cycle registered read.
// The table is computed at elaboration with short Taylor series over [0, pi/2).
module r4_twiddle_rom
  import r4_ifft_pkg::*;
(
  input  logic            clk,
  input  logic [LOGN-3:0] addr_i,
  output coef_t           c_o,
  output coef_t           s_o
);

  localparam int  NQ = N / 4;
  localparam real PI = 3.14159265358979323846;

  function automatic real sin_t(input real x);
    real term;
    real acc;
    term = x;
    acc  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic real cos_t(input real x);
    real term;
    real acc;
    term = 1.0;
    acc  = 1.0;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Table values are non-negative, so +0.5 then truncate is round-to-nearest.
  function automatic coef_t q14(input real x);
    return coef_t'($rtoi(x * real'(2 ** FRAC) + 0.5));
  endfunction

  logic [2*CW-1:0] tab_s [NQ];
  logic [2*CW-1:0] ent_q;

  for (genvar g = 0; g < NQ; g++) begin : g_tab
    localparam real THETA = 2.0 * PI * real'(g) / real'(N);
    assign tab_s[g] = {q14(cos_t(THETA)), q14(sin_t(THETA))};
  end

  // Registered ROM read.
  always_ff @(posedge clk) begin
    ent_q <= tab_s[addr_i];
  end

  assign c_o = coef_t'(ent_q[2*CW-1:CW]);
  assign s_o = coef_t'(ent_q[CW-1:0]);

endmodule

// File: rtl/r4_twiddle_mult.sv
// Radix-4 twiddle multiplier: quadrant-folded ROM lookup, complex multiply, round/saturate,
// 3-cycle pipeline and an N-sample frame marker. Saturation selected by R4_TWIDDLE_SAT_EN.
module r4_twiddle_mult
  import r4_ifft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  input  logic                    VALID,
  input  logic [11:0]             radix_address,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic                    OUT_VALID,
  output logic                    frame_last
);

  logic [LOGN-1:0]         k_s;
  logic [LOGN-3:0]         m_s;
  quad_t                   quad_s;
  coef_t                   c_s, s_s, wr_s, wi_s;
  logic signed [WIDTH-1:0] a1_q, b1_q;
  quad_t                   quad1_q;
  logic signed [PRODW-1:0] p_ar_q, p_bi_q, p_ai_q, p_br_q;
  logic signed [ACCW-1:0]  acc_re_s, acc_im_s;
  logic [2:0]              vld_q;
  logic [LOGN-1:0]         cnt_q;
  logic signed [WIDTH-1:0] out_r_q, out_i_q;
  logic                    fl_q;

  assign k_s    = LOGN'(radix_address % 12'(N));
  assign quad_s = quad_t'(k_s[LOGN-1 -: 2]);
  assign m_s    = k_s[LOGN-3:0];

  r4_twiddle_rom u_rom (
    .clk    (clk),
    .addr_i (m_s),
    .c_o    (c_s),
    .s_o    (s_s)
  );

  // S1: capture the sample and quadrant alongside the registered ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q    <= '0;
      b1_q    <= '0;
      quad1_q <= Q0;
    end else begin
      a1_q    <= data_in_r;
      b1_q    <= data_in_i;
      quad1_q <= quad_s;
    end
  end

  // Rotate the first-quadrant coefficient into the quadrant of k.
  always_comb begin
    wr_s = c_s;
    wi_s = s_s;
    case (quad1_q)
      Q0: begin wr_s = c_s;  wi_s = s_s;  end
      Q1: begin wr_s = -s_s; wi_s = c_s;  end
      Q2: begin wr_s = -c_s; wi_s = -s_s; end
      Q3: begin wr_s = s_s;  wi_s = -c_s; end
      default: begin wr_s = c_s; wi_s = s_s; end
    endcase
  end

  // S2: four real products.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_ar_q <= '0;
      p_bi_q <= '0;
      p_ai_q <= '0;
      p_br_q <= '0;
    end else begin
      p_ar_q <= a1_q * wr_s;
      p_bi_q <= b1_q * wi_s;
      p_ai_q <= a1_q * wi_s;
      p_br_q <= b1_q * wr_s;
    end
  end

  assign acc_re_s = ACCW'(p_ar_q) - ACCW'(p_bi_q);
  assign acc_im_s = ACCW'(p_ai_q) + ACCW'(p_br_q);

  // S3: valid pipeline, frame counter and output registers; data holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 3'b000;
      cnt_q   <= '0;
      out_r_q <= '0;
      out_i_q <= '0;
      fl_q    <= 1'b0;
    end else begin
      vld_q <= {vld_q[1:0], VALID};
      fl_q  <= vld_q[1] && (cnt_q == LOGN'(N - 1));
      if (vld_q[1]) begin
        out_r_q <= round_sat(acc_re_s);
        out_i_q <= round_sat(acc_im_s);
        cnt_q   <= (cnt_q == LOGN'(N - 1)) ? '0 : cnt_q + LOGN'(1);
      end
    end
  end

  assign data_out_r = out_r_q;
  assign data_out_i = out_i_q;
  assign OUT_VALID  = vld_q[2];
  assign frame_last = fl_q;

endmodule

// File: doc/r4_twiddle_mult.md
# r4_twiddle_mult

Twiddle-factor multiplier that consumes the serial output stream of a radix-4 SDF butterfly stage in the 5G NR IFFT/CP chain. It takes the butterfly's sample, its valid flag and its twiddle index (`radix_address`), looks up e^{+j2πk/N} from a quadrant-folded ROM, and performs the complex multiply. It then rounds and saturates the result back to `WIDTH` and hands it to the next butterfly stage. A frame counter marks the last sample of each N-point symbol.

## Interface
- `WIDTH`, 26: real/imag sample width, two's complement.
- `CW`, 16: coefficient width, Q2.14 (FRAC = CW-2 = 14; +1.0 = 16384).
- `N`, 2048: transform size; index taken modulo N.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `data_in_r`  in  WIDTH  signed real sample from the butterfly stage.
- `data_in_i`  in  WIDTH  signed imag sample.
- `VALID`  in  1  qualifies the data and address this cycle.
- `radix_address`  in  12  twiddle index k.
- `data_out_r`  out  WIDTH  signed real product.
- `data_out_i`  out  WIDTH  signed imag product.
- `OUT_VALID`  out  1  qualifies the outputs.
- `frame_last`  out  1  high with the N-th valid output of a frame.

## Operation
- No backpressure. Every cycle with `VALID`=1 produces exactly one output.
- Cycles with `VALID`=0 are bubbles. They propagate with `OUT_VALID`=0, and the data outputs hold their last value.
- Index handling:
  - k = `radix_address` mod N, i.e. the low log2(N) bits.
  - q = k[log2(N)-1 -: 2]; m = k mod N/4.
- ROM stores c(m) = round(cos(2πm/N)·2^14) and s(m) = round(sin(2πm/N)·2^14) for m = 0..N/4-1.
- Quadrant rotation (W = e^{+jθ}, IFFT sign):
  - q0: (c, s)
  - q1: (-s, c)
  - q2: (-c, -s)
  - q3: (s, -c)
- Product:
  - re = a·Wr − b·Wi
  - im = a·Wi + b·Wr
  - Accumulator width WIDTH+CW+1, so no internal overflow.
- Scaling: result = (acc + 2^13) >>> 14, i.e. round-half-up, arithmetic shift.
- Saturation: result clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; see Configuration.
- Frame counter:
  - Counts valid outputs 0..N−1 and wraps to 0.
  - `frame_last` = `OUT_VALID` & (count == N−1). It is a one-cycle pulse.
- Pipeline control is a 3-deep valid shift register. There is no other FSM.
- Frame counter states: COUNTING, then wrap at N−1 back to 0.

## Timing
- Latency is exactly 3 cycles from a `VALID` input to `OUT_VALID`, for every k including k=0. Pipeline stages:
  - S1: register input, k and quadrant, ROM read.
  - S2: four real multiplies, registered.
  - S3: add/sub, round, saturate, register outputs.
- Throughput is 1 sample/cycle, sustained indefinitely.
- Reset values: `data_out_r`/`data_out_i` = 0, `OUT_VALID` = 0, `frame_last` = 0, frame counter = 0, all pipeline valid bits = 0.
- Reset mid-operation:
  - In-flight samples are discarded.
  - `OUT_VALID` is 0 in the cycle after `rst` is sampled high, and stays 0 until 3 cycles after the first post-reset `VALID`.
- Frame counter wrap and a new frame's first sample in the same cycle: the counter goes N−1 → 0, and the next valid output counts as index 0.
- `radix_address` ≥ N is accepted and wrapped; it is not an error.

## Configuration
- `R4_TWIDDLE_SAT_EN` defined: S3 clamps to the signed WIDTH range, as in Operation.
- Not defined: S3 truncates to the low WIDTH bits (two's-complement wrap) and the saturation logic is removed.
- All other behaviour and latency are identical in both builds.

## Structure
- Package `r4_ifft_pkg`:
  - `WIDTH`, `CW`, `FRAC`, `N` defaults.
  - Quadrant typedef (2-bit enum Q0..Q3).
  - Coefficient typedef `signed [CW-1:0]`.
  - Round/saturate function.
- Sub-module `r4_twiddle_rom`:
  - Registered read, N/4 entries of {c, s}.
  - Table generated at elaboration from the package constants.
- Top level holds the pipeline, quadrant rotation and frame counter.

## Test plan
- k=0, in (1000, −500) → 3 cycles later out (1000, −500), `OUT_VALID`=1.
- k=512 (q1), in (1000, 0) → out (0, 1000); k=1024 → (−1000, 0); k=1536 → (0, −1000).
- k=256 (45°, c=s=11585), in (16384, 0) → out (11585, 11585); k=256+2048 gives the same result.
- k=256, in (2^25−1, 2^25−1):
  - With `R4_TWIDDLE_SAT_EN`: out (0, 33554431).
  - Without it: imag equals the wrapped low 26 bits of the exact rounded sum.
- `VALID` toggling 1,0,1,0 for 4096 cycles → outputs mirror the gaps with 3-cycle lag, and `frame_last` pulses exactly on the 2048th valid output.
- 2 samples in flight, `rst` high for 1 cycle → `OUT_VALID`=0 next cycle, no stale samples emitted, and the counter restarts at 0.
